// File: rtl/grp_bank_ctrl_if.sv
// grp_bank_ctrl_if: filler, frame-former and bank-memory signals of the ping-pong group buffer
interface grp_bank_ctrl_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10
);
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic              wr_sync;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              swap_req;
  logic              m0_wren;
  logic              m1_wren;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m0_rden;
  logic              m1_rden;
  logic [DATA_W-1:0] m0_q;
  logic [DATA_W-1:0] m1_q;
  logic              bank_sel;
  logic              rd_valid;
  logic [7:0]        underrun_cnt;
  modport slave (
    input  wr_data, wr_valid, wr_sync, rd_en, rd_addr, swap_req, m0_q, m1_q,
    output wr_ready, rd_data, m0_wren, m1_wren, wr_addr, m_wdata, m0_rden, m1_rden,
           bank_sel, rd_valid, underrun_cnt
  );
  modport master (
    output wr_data, wr_valid, wr_sync, rd_en, rd_addr, swap_req, m0_q, m1_q,
    input  wr_ready, rd_data, m0_wren, m1_wren, wr_addr, m_wdata, m0_rden, m1_rden,
           bank_sel, rd_valid, underrun_cnt
  );
endinterface

// File: rtl/grp_bank_ctrl.sv
// grp_bank_ctrl: ping-pong bank controller, filler writes one bank while the frame-former reads the other
module grp_bank_ctrl #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic           clk,
  input  logic           reset,
  grp_bank_ctrl_if.slave bus
);
  typedef enum logic {FILL, FULL} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t            r_state, w_state_nx;
  logic [ADDR_W-1:0] r_wr_ptr, w_wr_ptr_nx;
  logic              r_bank_sel, r_rd_valid, r_bank_q, r_oob;
  logic [7:0]        r_underrun;
  logic              w_accept, w_last, w_swap_ok, w_wen;
  assign bus.wr_ready     = r_state == FILL;
  assign w_accept         = bus.wr_valid & bus.wr_ready;
  assign w_last           = w_accept & (r_wr_ptr == LAST);
  assign w_swap_ok        = bus.swap_req & ~bus.wr_sync & ((r_state == FULL) | w_last);
  assign w_wen            = w_accept & reset;
  assign bus.m0_wren      = w_wen & r_bank_sel;
  assign bus.m1_wren      = w_wen & ~r_bank_sel;
  assign bus.wr_addr      = bus.wr_sync ? '0 : r_wr_ptr;
  assign bus.m_wdata      = bus.wr_data;
  assign bus.m0_rden      = bus.rd_en & ~r_bank_sel;
  assign bus.m1_rden      = bus.rd_en & r_bank_sel;
  assign bus.bank_sel     = r_bank_sel;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.underrun_cnt = r_underrun;
  assign bus.rd_data      = (r_rd_valid & ~r_oob) ? (r_bank_q ? bus.m1_q : bus.m0_q) : '0;
  // write FSM state and fill pointer
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state  <= FILL;
      r_wr_ptr <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_wr_ptr <= w_wr_ptr_nx;
    end
  // next state: sync restarts the group, a granted swap reopens the old read bank, the final word closes it
  always_comb begin
    w_state_nx  = (bus.wr_sync | w_swap_ok) ? FILL : w_last ? FULL : r_state;
    w_wr_ptr_nx = bus.wr_sync ? ADDR_W'(w_accept) :
                  (w_swap_ok | w_last) ? '0 :
                  w_accept ? r_wr_ptr + 1'b1 : r_wr_ptr;
  end
  // bank ownership, group-valid flag and saturating count of refused swaps
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_bank_sel <= 1'b0;
      r_rd_valid <= 1'b0;
      r_underrun <= '0;
    end else begin
      r_bank_sel <= r_bank_sel ^ w_swap_ok;
      r_rd_valid <= r_rd_valid | w_swap_ok;
      r_underrun <= r_underrun + 8'(bus.swap_req & ~w_swap_ok & (r_underrun != 8'hFF));
    end
  // remember which bank and whether the address was in range for the word returning next cycle
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_bank_q <= 1'b0;
      r_oob    <= 1'b0;
    end else if (bus.rd_en) begin
      r_bank_q <= r_bank_sel;
      r_oob    <= {{(32-ADDR_W){1'b0}}, bus.rd_addr} >= 32'(DEPTH);
    end
endmodule
